axis_packet_arbiter: RTL and testbench
======================================

Name: axis_packet_arbiter

Overview:
- Merges N_S AXI-Stream source ports into one master port. Arbitration is round-robin and packet-granular: a winner keeps the output until its tlast beat is accepted.
- Sits in front of the systolic-array input DMA/stream path so several producers (weights, activations, config streams) share one AXIS link into the array.
- Output is a registered slice: one beat of storage and full throughput once a grant is held.

Parameters:
- N_S, 4, number of source ports (>=1).
- WORD_W, 8, bits per word.
- BUS_W, 32, bits per beat. Must be a multiple of WORD_W.
- WORDS_PER_BEAT, BUS_W/WORD_W, derived value; do not override.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- s_valid  in  N_S  per-source tvalid.
- s_ready  out  N_S  per-source tready.
- s_last  in  N_S  per-source tlast.
- s_keep  in  N_S x WORDS_PER_BEAT  per-source tkeep, one bit per word.
- s_data  in  N_S x WORDS_PER_BEAT x WORD_W  per-source tdata.
- m_valid  out  1  output tvalid.
- m_ready  in  1  output tready.
- m_last  out  1  output tlast.
- m_keep  out  WORDS_PER_BEAT  output tkeep.
- m_data  out  WORDS_PER_BEAT x WORD_W  output tdata.
- m_id  out  max(1,$clog2(N_S))  source index of the current beat. Present only with AXIS_ARB_ID_EN.

Behaviour:
- Reset (rstn=0, async):
  - m_valid=0, m_last=0, m_keep=0, m_data=0, s_ready=0 on all ports, m_id=0.
  - state=IDLE; priority pointer ptr=N_S-1, so source 0 has first priority.
- Reset asserted mid-packet: the packet is abandoned with no partial flush. After release the arbiter is in IDLE.
- Two-state FSM, IDLE and LOCK:
  - IDLE:
    - s_ready=0 on all ports.
    - If any s_valid is high, grant the first requester found searching ptr+1, ptr+2, ... modulo N_S. Register sel=winner and go to LOCK.
    - Cost: one arbitration bubble cycle per packet.
    - If no s_valid is high, stay in IDLE.
  - LOCK:
    - s_ready[sel] = (!m_valid || m_ready). All other s_ready bits are 0.
    - When s_valid[sel] && s_ready[sel]: load {data, keep, last} into the output register and set m_valid=1 on the next edge.
    - When m_valid && m_ready and no new load happens in the same cycle: m_valid returns to 0.
    - Accepted beat with s_last[sel]=1: ptr<=sel and state<=IDLE on the same edge. The output register still holds that last beat until it drains.
- Latency: a beat accepted on edge k appears on m_* after edge k. Throughput is 1 beat/cycle while in LOCK with m_ready held high.
- Simultaneous load and drain in the same cycle: the output register is overwritten and m_valid stays 1, so there is no bubble.
- Beats pass through unmodified: data, keep and last are copied verbatim. Beats with all-zero keep are forwarded as-is, and lanes with keep=0 are still forwarded.
- s_valid[sel] low mid-packet: the grant is held and the output shows bubbles. Other sources wait; there is no preemption.
- Returning to IDLE while m_valid=1 with m_ready=0 is allowed. The next winner cannot load until the register drains, because of the s_ready rule.
- N_S=1: round-robin degenerates to always granting port 0. Keep the one bubble cycle per packet.
- m_* must hold stable while m_valid=1 and m_ready=0 (AXIS rule).

Optional Feature:
- AXIS_ARB_ID_EN defined:
  - The m_id port exists. It is registered together with m_data and equals the sel value of the beat being presented.
  - Reset value is 0.
- AXIS_ARB_ID_EN undefined: the m_id port and its register are absent. All other behaviour is identical.

Test Plan:
- Reset then single source: source 2 pushes a 3-beat packet with keep=4'b1111, 4'b1111, 4'b0011 and m_ready=1. Expect the identical 3 beats with m_last only on beat 3, the first beat 2 cycles after s_valid rises, and m_id=2.
- All 4 sources hold 1-beat packets continuously after reset. Expect grant order 0,1,2,3,0,1... Check that ptr wraps from 3 to 0.
- Source 0 sends a 5-beat packet and source 1 asserts s_valid at beat 2. Expect s_ready[1]=0 until source 0's last beat is accepted, then source 1's packet, with no interleaving.
- Backpressure: m_ready toggles per cycle under random 10%-ready stall. Expect m_data/m_keep/m_last stable while stalled, no beat dropped or duplicated, and a random 1-100 word packet matching word-for-word.
- rstn pulsed low at beat 3 of an 8-beat packet. Expect m_valid=0 and all s_ready=0 immediately (async). After release, source 0 is granted first when sources 0 and 3 both request.
- m_ready held 1 during a 4-beat packet. Expect m_valid high on 4 consecutive cycles: a same-cycle load and drain gives no bubble.

Source files
------------

// File: rtl/axis_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axis_packet_arbiter
// Purpose  : Round-robin, packet-granular merge of N_S AXI-Stream sources into
//            one registered master port. Define AXIS_ARB_ID_EN to add m_id.
// Revision : 1.0 - initial release
// ============================================================================
module axis_packet_arbiter #(
    parameter int N_S            = 4,
    parameter int WORD_W         = 8,
    parameter int BUS_W          = 32,
    parameter int WORDS_PER_BEAT = BUS_W / WORD_W,
    parameter int ID_W           = (N_S > 1) ? $clog2(N_S) : 1
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [N_S-1:0]                       s_valid,
    output logic [N_S-1:0]                       s_ready,
    input  logic [N_S-1:0]                       s_last,
    input  logic [N_S*WORDS_PER_BEAT-1:0]        s_keep,
    input  logic [N_S*WORDS_PER_BEAT*WORD_W-1:0] s_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic                                 m_last,
    output logic [WORDS_PER_BEAT-1:0]            m_keep,
    output logic [WORDS_PER_BEAT*WORD_W-1:0]     m_data
`ifdef AXIS_ARB_ID_EN
    ,
    output logic [ID_W-1:0]                      m_id
`endif
);

    localparam logic [0:0]      c_IDLE    = 1'b0;
    localparam logic [0:0]      c_LOCK    = 1'b1;
    localparam int              c_BEAT_W  = WORDS_PER_BEAT * WORD_W;
    localparam logic [ID_W-1:0] c_PTR_RST = ID_W'(N_S - 1);

    logic [0:0]                r_state;
    logic [0:0]                w_state_nxt;
    logic [ID_W-1:0]           r_ptr;
    logic [ID_W-1:0]           w_ptr_nxt;
    logic [ID_W-1:0]           r_sel;
    logic [ID_W-1:0]           w_sel_nxt;
    logic [ID_W-1:0]           w_win;
    logic                      w_slot_free;
    logic                      w_load;
    logic                      w_sel_valid;
    logic                      w_sel_last;
    logic [WORDS_PER_BEAT-1:0] w_sel_keep;
    logic [c_BEAT_W-1:0]       w_sel_data;
    logic                      r_m_valid;
    logic                      r_m_last;
    logic [WORDS_PER_BEAT-1:0] r_m_keep;
    logic [c_BEAT_W-1:0]       r_m_data;

    assign w_sel_valid = s_valid[r_sel];
    assign w_sel_last  = s_last[r_sel];
    assign w_sel_keep  = s_keep[r_sel*WORDS_PER_BEAT +: WORDS_PER_BEAT];
    assign w_sel_data  = s_data[r_sel*c_BEAT_W +: c_BEAT_W];
    assign w_slot_free = !r_m_valid || m_ready;

    // Scan from the farthest slot back to ptr+1 so the nearest requester wins.
    always_comb begin
        w_win = r_ptr;
        for (int k = N_S; k >= 1; k--) begin
            if (s_valid[ID_W'((int'(r_ptr) + k) % N_S)]) begin
                w_win = ID_W'((int'(r_ptr) + k) % N_S);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_load      = 1'b0;
        s_ready     = '0;
        case (r_state)
            c_IDLE: begin
                if (|s_valid) begin
                    w_state_nxt = c_LOCK;
                    w_sel_nxt   = w_win;
                end
            end
            c_LOCK: begin
                s_ready[r_sel] = w_slot_free;
                w_load         = w_sel_valid && w_slot_free;
                if (w_load && w_sel_last) begin
                    w_state_nxt = c_IDLE;
                    w_ptr_nxt   = r_sel;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_IDLE;
            r_sel   <= '0;
            r_ptr   <= c_PTR_RST;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Output slice: a load and a drain in the same cycle keep m_valid high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_keep  <= '0;
            r_m_data  <= '0;
        end else if (w_load) begin
            r_m_valid <= 1'b1;
            r_m_last  <= w_sel_last;
            r_m_keep  <= w_sel_keep;
            r_m_data  <= w_sel_data;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_valid = r_m_valid;
    assign m_last  = r_m_last;
    assign m_keep  = r_m_keep;
    assign m_data  = r_m_data;

`ifdef AXIS_ARB_ID_EN
    logic [ID_W-1:0] r_m_id;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_m_id <= '0;
        end else if (w_load) begin
            r_m_id <= r_sel;
        end
    end

    assign m_id = r_m_id;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_packet_arbiter
// Purpose  : Self-checking bench for axis_packet_arbiter (table, directed and
//            randomized packets against a packet-level round-robin model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_packet_arbiter;

    localparam int c_NS  = 4;
    localparam int c_WPB = 4;
    localparam int c_BW  = 32;

    typedef struct {
        logic [c_BW-1:0]  data;
        logic [c_WPB-1:0] keep;
        logic             last;
    } beat_t;

    typedef struct {
        logic [c_NS-1:0] s_valid;
        logic            m_ready;
        logic [c_NS-1:0] exp_s_ready;
        logic            exp_m_valid;
        logic [c_BW-1:0] exp_m_data;
    } vec_t;

    logic                  clk;
    logic                  rstn;
    logic [c_NS-1:0]       s_valid;
    logic [c_NS-1:0]       s_ready;
    logic [c_NS-1:0]       s_last;
    logic [c_NS*c_WPB-1:0] s_keep;
    logic [c_NS*c_BW-1:0]  s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;
    logic [c_WPB-1:0]      m_keep;
    logic [c_BW-1:0]       m_data;
`ifdef AXIS_ARB_ID_EN
    logic [1:0]            m_id;
    int                    cap_id;
`endif

    int    total = 0;
    int    bad   = 0;
    beat_t src_q[c_NS][$];
    beat_t exp_q[c_NS][$];
    bit    mid[c_NS];
    int    m_ptr;
    int    cur;
    int    cyc;
    int    out_cyc[$];
    int    out_src[$];
    bit    prev_stall;
    beat_t held;
    int    excl_viol;
    vec_t  vecs[16];

    axis_packet_arbiter #(.N_S(c_NS), .WORD_W(8), .BUS_W(c_BW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_last  (s_last),
        .s_keep  (s_keep),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last),
        .m_keep  (m_keep),
        .m_data  (m_data)
`ifdef AXIS_ARB_ID_EN
        ,
        .m_id    (m_id)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        rstn    = 1'b0;
        s_valid = '0;
        s_last  = '0;
        s_keep  = '0;
        m_ready = 1'b0;
        for (int i = 0; i < c_NS; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            mid[i] = 1'b0;
        end
        m_ptr      = c_NS - 1;
        cur        = -1;
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic start_seq();
        cyc       = 0;
        excl_viol = 0;
        out_cyc.delete();
        out_src.delete();
    endtask

    task automatic push_beat(input int src, input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        src_q[src].push_back(b);
        exp_q[src].push_back(b);
    endtask

    task automatic add_rand_pkt(input int src);
        int words;
        int nb;
        int rem;
        words = $urandom_range(1, 100);
        nb    = (words + c_WPB - 1) / c_WPB;
        for (int b = 0; b < nb; b++) begin
            rem = words - b * c_WPB;
            push_beat(src, $urandom, (rem >= c_WPB) ? 4'hF : (4'hF >> (c_WPB - rem)), b == nb - 1);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < c_NS; i++)
            if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Packet-level model: the next packet comes from the first source after
    // the previous winner that still has packets queued.
    task automatic check_out(input beat_t ob);
        beat_t e;
        int    j;
        out_cyc.push_back(cyc);
        if (cur < 0) begin
            j = m_ptr;
            for (int n = 0; n < c_NS && cur < 0; n++) begin
                j = (j + 1) % c_NS;
                if (exp_q[j].size() > 0) cur = j;
            end
            if (cur < 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got data %0h, required no beat", ob.data);
                return;
            end
            out_src.push_back(cur);
        end
        e = exp_q[cur].pop_front();
        chk("m_data", ob.data, e.data);
        chk("m_keep", ob.keep, e.keep);
        chk("m_last", ob.last, e.last);
`ifdef AXIS_ARB_ID_EN
        chk("m_id", cap_id, cur);
`endif
        if (e.last) begin
            m_ptr = cur;
            cur   = -1;
        end
    endtask

    task automatic drive_inputs(input int rdy_pct, input int gap_pct);
        m_ready = ($urandom_range(0, 99) < rdy_pct);
        for (int i = 0; i < c_NS; i++) begin
            if (src_q[i].size() > 0) begin
                s_valid[i]              = mid[i] ? ($urandom_range(0, 99) >= gap_pct) : 1'b1;
                s_data[i*c_BW +: c_BW]  = src_q[i][0].data;
                s_keep[i*c_WPB +: c_WPB] = src_q[i][0].keep;
                s_last[i]               = src_q[i][0].last;
            end else begin
                s_valid[i]               = 1'b0;
                s_last[i]                = 1'b0;
                s_keep[i*c_WPB +: c_WPB] = '0;
            end
        end
    endtask

    task automatic cycle(input int rdy_pct, input int gap_pct);
        logic [c_NS-1:0] fire;
        bit              ofire;
        beat_t           ob;
        drive_inputs(rdy_pct, gap_pct);
        @(negedge clk);
        if (prev_stall)
            chk("stall_hold", {m_valid, m_last, m_keep, m_data}, {1'b1, held.last, held.keep, held.data});
        prev_stall = m_valid && !m_ready;
        held.data  = m_data;
        held.keep  = m_keep;
        held.last  = m_last;
        if ($countones(s_ready) > 1) excl_viol++;
        for (int i = 0; i < c_NS; i++)
            for (int j = 0; j < c_NS; j++)
                if (i != j && s_ready[i] && mid[j]) excl_viol++;
        fire  = s_valid & s_ready;
        ofire = m_valid && m_ready;
        ob    = held;
`ifdef AXIS_ARB_ID_EN
        cap_id = int'(m_id);
`endif
        @(posedge clk);
        #1;
        for (int i = 0; i < c_NS; i++) begin
            if (fire[i]) begin
                mid[i] = !src_q[i][0].last;
                void'(src_q[i].pop_front());
            end
        end
        if (ofire) check_out(ob);
        cyc++;
    endtask

    task automatic run_drain(input string name, input int rdy_pct, input int gap_pct, input int budget);
        int n;
        n = 0;
        while (!all_empty() && n < budget) begin
            cycle(rdy_pct, gap_pct);
            n++;
        end
        chk({name, "_done_in_budget"}, all_empty(), 1);
    endtask

    initial begin
        rstn    = 1'b1;
        s_valid = '0;
        s_last  = '0;
        s_keep  = '0;
        s_data  = '0;
        m_ready = 1'b0;

        // {s_valid, m_ready, exp s_ready, exp m_valid, exp m_data}; all beats are 1-beat packets
        vecs[0]  = '{4'hF, 1'b1, 4'h0, 1'b0, 32'h0};
        vecs[1]  = '{4'hF, 1'b1, 4'h1, 1'b0, 32'h0};
        vecs[2]  = '{4'hF, 1'b1, 4'h0, 1'b1, 32'hA0A0A0A0};
        vecs[3]  = '{4'hF, 1'b1, 4'h2, 1'b0, 32'h0};
        vecs[4]  = '{4'hF, 1'b1, 4'h0, 1'b1, 32'hA1A1A1A1};
        vecs[5]  = '{4'hF, 1'b1, 4'h4, 1'b0, 32'h0};
        vecs[6]  = '{4'hF, 1'b1, 4'h0, 1'b1, 32'hA2A2A2A2};
        vecs[7]  = '{4'hF, 1'b1, 4'h8, 1'b0, 32'h0};
        vecs[8]  = '{4'hF, 1'b1, 4'h0, 1'b1, 32'hA3A3A3A3};
        vecs[9]  = '{4'hF, 1'b1, 4'h1, 1'b0, 32'h0};
        vecs[10] = '{4'hF, 1'b1, 4'h0, 1'b1, 32'hA0A0A0A0};
        vecs[11] = '{4'hF, 1'b0, 4'h2, 1'b0, 32'h0};
        vecs[12] = '{4'hF, 1'b0, 4'h0, 1'b1, 32'hA1A1A1A1};
        vecs[13] = '{4'hF, 1'b0, 4'h0, 1'b1, 32'hA1A1A1A1};
        vecs[14] = '{4'hF, 1'b1, 4'h4, 1'b1, 32'hA1A1A1A1};
        vecs[15] = '{4'hF, 1'b1, 4'h0, 1'b1, 32'hA2A2A2A2};

        // Reset state, with requests present to show s_ready stays low
        #2 rstn = 1'b0;
        s_valid = '1;
        @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_keep", m_keep, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_s_ready", s_ready, 0);
`ifdef AXIS_ARB_ID_EN
        chk("rst_m_id", m_id, 0);
`endif
        reset_dut();

        // Round-robin order with wrap, stall and same-cycle load/drain
        s_data = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
        s_keep = '1;
        s_last = '1;
        for (int r = 0; r < 16; r++) begin
            s_valid = vecs[r].s_valid;
            m_ready = vecs[r].m_ready;
            @(negedge clk);
            chk($sformatf("vec%0d_s_ready", r), s_ready, vecs[r].exp_s_ready);
            chk($sformatf("vec%0d_m_valid", r), m_valid, vecs[r].exp_m_valid);
            if (vecs[r].exp_m_valid) begin
                chk($sformatf("vec%0d_m_data", r), m_data, vecs[r].exp_m_data);
                chk($sformatf("vec%0d_m_last", r), m_last, 1);
            end
            @(posedge clk);
            #1;
        end
        reset_dut();

        // Single 3-beat packet from source 2: first beat two cycles after s_valid
        start_seq();
        push_beat(2, 32'h11223344, 4'hF, 1'b0);
        push_beat(2, 32'h55667788, 4'hF, 1'b0);
        push_beat(2, 32'h99AABBCC, 4'h3, 1'b1);
        run_drain("t1", 100, 0, 100);
        chk("t1_beat_count", out_cyc.size(), 3);
        if (out_cyc.size() == 3) begin
            chk("t1_first_latency", out_cyc[0], 2);
            chk("t1_last_cycle", out_cyc[2], 4);
        end
        if (out_src.size() > 0) chk("t1_source", out_src[0], 2);

        // 4-beat packet, m_ready high: consecutive beats, odd keep patterns pass through
        start_seq();
        push_beat(3, 32'hDEAD0001, 4'hF, 1'b0);
        push_beat(3, 32'hDEAD0002, 4'h0, 1'b0);
        push_beat(3, 32'hDEAD0003, 4'h5, 1'b0);
        push_beat(3, 32'hDEAD0004, 4'h1, 1'b1);
        run_drain("t6", 100, 0, 100);
        chk("t6_beat_count", out_cyc.size(), 4);
        if (out_cyc.size() == 4) chk("t6_no_bubble", out_cyc[3] - out_cyc[0], 3);

        // Source 1 requests while source 0 is mid-packet: no interleaving
        start_seq();
        for (int b = 0; b < 5; b++) push_beat(0, 32'hC0000000 + b, 4'hF, b == 4);
        cycle(100, 0);
        cycle(100, 0);
        for (int b = 0; b < 2; b++) push_beat(1, 32'hC1000000 + b, 4'hF, b == 1);
        run_drain("t3", 100, 0, 100);
        chk("t3_exclusive_grant", excl_viol, 0);
        chk("t3_packets", out_src.size(), 2);
        if (out_src.size() == 2) begin
            chk("t3_first_src", out_src[0], 0);
            chk("t3_second_src", out_src[1], 1);
        end

        // Async reset at beat 3 of an 8-beat packet
        start_seq();
        for (int b = 0; b < 8; b++) push_beat(0, 32'hE0000000 + b, 4'hF, b == 7);
        for (int n = 0; n < 50 && src_q[0].size() > 5; n++) cycle(100, 0);
        chk("t5_mid_valid", m_valid, 1);
        rstn = 1'b0;
        #1;
        chk("t5_async_m_valid", m_valid, 0);
        chk("t5_async_s_ready", s_ready, 0);
        reset_dut();
        start_seq();
        push_beat(3, 32'hF3F3F3F3, 4'hF, 1'b1);
        push_beat(0, 32'hF0F0F0F0, 4'hF, 1'b1);
        run_drain("t5", 100, 0, 100);
        chk("t5_packets", out_src.size(), 2);
        if (out_src.size() == 2) begin
            chk("t5_first_src", out_src[0], 0);
            chk("t5_second_src", out_src[1], 3);
        end

        // Randomized packets: heavy backpressure, then moderate
        start_seq();
        for (int i = 0; i < c_NS; i++)
            for (int p = $urandom_range(1, 3); p > 0; p--) add_rand_pkt(i);
        run_drain("rand_slow", 10, 20, 30000);
        chk("rand_slow_exclusive", excl_viol, 0);

        start_seq();
        for (int i = 0; i < c_NS; i++)
            for (int p = $urandom_range(1, 3); p > 0; p--) add_rand_pkt(i);
        run_drain("rand_fast", 70, 30, 30000);
        chk("rand_fast_exclusive", excl_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
